// File: rtl/mem_wait_ctrl_pkg.sv
// Shared definitions for the memory wait-state controller:
// FSM state encoding and the word-alignment mask.
package mem_wait_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Low address bits that must be zero for a word access
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] a);
    return (a & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wait_ctrl_sat_counter16.sv
// sat_counter16: 16-bit event counter that sticks at 16'hFFFF instead of
// wrapping, so a long run never reports a misleadingly small count.
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] r_count;

  // Count enabled events, holding at the top value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl: sits between the CPU memory port and a word memory.
// A single-cycle request becomes IDLE -> WAIT (WAIT_CYCLES cycles) ->
// ACCESS (one cycle) -> DONE (ready pulse). Misaligned word addresses skip
// straight to DONE with err set and never touch memory.
// Optional build macro MEM_WAIT_STATS_EN adds saturating read/write/stall
// counters (stat_reads, stat_writes, stat_stalls).
module mem_wait_ctrl
  import mem_wait_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ready,
  output logic          busy,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
`ifdef MEM_WAIT_STATS_EN
  ,
  output logic [15:0]   stat_reads,
  output logic [15:0]   stat_writes,
  output logic [15:0]   stat_stalls
`endif
);

  // Counter preload: WAIT_CYCLES-1 so that the zero test ends WAIT after
  // exactly WAIT_CYCLES cycles. Unused when there are no wait states.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic          r_err;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          w_accept;
  logic          w_misaligned;

  // Requests are only seen in IDLE; anything arriving later is dropped
  assign w_accept     = (r_state == IDLE) && req;
  assign w_misaligned = is_misaligned(addr[1:0]);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and state-decoded handshake outputs
  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    busy   = 1'b0;
    mem_we = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          if (w_misaligned) begin
            w_next = DONE;
          end else if (WAIT_CYCLES == 0) begin
            w_next = ACCESS;
          end else begin
            w_next = WAIT;
          end
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (r_cnt == 4'd0) begin
          w_next = ACCESS;
        end
      end
      ACCESS: begin
        busy   = 1'b1;
        // Qualified by state so reset drops the strobe without a clock
        mem_we = r_we;
        w_next = DONE;
      end
      DONE: begin
        ready  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Capture the request; err is replaced on every accepted request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= addr;
      r_wdata <= wdata;
      r_we    <= we;
      r_err   <= w_misaligned;
    end
  end

  // Wait-state down-counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= WAIT_LOAD;
    end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Read data captured at the end of ACCESS and held until the next read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if ((r_state == ACCESS) && !r_we) begin
      r_rdata <= mem_dout;
    end
  end

  assign rdata    = r_rdata;
  assign err      = r_err;
  assign mem_addr = r_addr;
  assign mem_din  = r_wdata;

`ifdef MEM_WAIT_STATS_EN
  logic w_rd_done;
  logic w_wr_done;
  logic w_stall;

  // ACCESS is only reached by aligned requests and always completes
  assign w_rd_done = (r_state == ACCESS) && !r_we;
  assign w_wr_done = (r_state == ACCESS) && r_we;
  assign w_stall   = (r_state == WAIT);

  sat_counter16 u_stat_reads (
    .clk   (clk),
    .reset (reset),
    .inc   (w_rd_done),
    .count (stat_reads)
  );

  sat_counter16 u_stat_writes (
    .clk   (clk),
    .reset (reset),
    .inc   (w_wr_done),
    .count (stat_writes)
  );

  sat_counter16 u_stat_stalls (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall),
    .count (stat_stalls)
  );
`endif

endmodule
